// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the adder arbiters: FSM state encoding and a clog2 helper.
package add_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } arb_state_e;

    // Ceiling log2, never less than 1 so it can size a bus directly.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/add_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts at ptr+1 (mod NREQ), first set req wins.
module add_arbiter_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    int unsigned idx;
    logic [IDW-1:0] sel;

    // Walk the requesters in rotated order and stop at the first valid one.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = 0;
        sel        = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = ptr;
            idx = (idx + i) % NREQ;
            sel = IDW'(idx);
            if (!any && req[sel]) begin
                any             = 1'b1;
                gnt_idx         = sel;
                gnt_onehot[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one external registered adder among NREQ requesters.
// Build option ADD_ARB_PIPE_EN: grant every cycle, ownership tracked by a shift register;
// otherwise a two-state FSM keeps a single transaction outstanding.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned IDW     = clog2_min1(NREQ)
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active low
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_out,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data
);

    localparam int unsigned CNTW = clog2_min1(ADD_LAT + 1);

    logic [NREQ-1:0] gnt_onehot;
    logic [IDW-1:0]  gnt_idx;
    logic            any;
    logic            grant_ok;
    logic            grant;

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [W-1:0]    add_a_q, add_a_d, add_b_q, add_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;

    add_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    assign req_ready = grant_ok ? gnt_onehot : '0;
    assign grant     = grant_ok & any;

    // On a grant, load the winner's operands and move the priority pointer to it.
    always_comb begin
        ptr_d   = ptr_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        if (grant) begin
            ptr_d   = gnt_idx;
            add_a_d = req_a[int'(gnt_idx)*W +: W];
            add_b_d = req_b[int'(gnt_idx)*W +: W];
        end
    end

`ifdef ADD_ARB_PIPE_EN
    logic [ADD_LAT:0]          vld_q, vld_d;
    logic [ADD_LAT:0][IDW-1:0] id_q, id_d;

    assign grant_ok = 1'b1;

    // Shift ownership along with the adder pipeline; capture when the oldest entry emerges.
    always_comb begin
        vld_d      = {vld_q[ADD_LAT-1:0], grant};
        id_d       = {id_q[ADD_LAT-1:0], gnt_idx};
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (vld_q[ADD_LAT]) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q[ADD_LAT];
            rsp_data_d  = add_out;
        end
    end

    // Ownership shift register; in-flight entries are dropped on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end
`else
    arb_state_e      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]  owner_q, owner_d;

    // Single-outstanding FSM: grant in idle, count down the adder latency, then respond.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        grant_ok    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            StIdle: begin
                grant_ok = 1'b1;
                if (any) begin
                    state_d = StWait;
                    cnt_d   = CNTW'(ADD_LAT);
                    owner_d = gnt_idx;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = owner_q;
                    rsp_data_d  = add_out;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, latency counter and owner of the outstanding transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end
`endif

    // Pointer, operand and response registers; pointer resets so requester 0 goes first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= IDW'(NREQ - 1);
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule
